// File: rtl/ssp_rx_fifo.sv
// SSP receive FIFO: storage plus pointer, count and flag control with a
// first-word-fall-through read port and a sticky overrun flag.
module ssp_rx_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 3,
    parameter int WATERMARK  = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  MS,
    input  logic                  TESTFIFO,
    input  logic                  MRxFWrEn,
    input  logic [DATA_WIDTH-1:0] MRxFWrData,
    input  logic                  SRxFWrEn,
    input  logic [DATA_WIDTH-1:0] SRxFWrData,
    input  logic                  TestWrEn,
    input  logic [DATA_WIDTH-1:0] PWDATAIn,
    input  logic                  RxFRdEn,
    input  logic                  OverrunClr,
    output logic [DATA_WIDTH-1:0] RxFRdData,
    output logic                  RxFEmpty,
    output logic                  RxFFull,
    output logic [ADDR_W:0]       RxFCount,
    output logic                  RxFWatermark,
    output logic                  RxOverrun
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] WM_CNT   = (ADDR_W + 1)'(WATERMARK);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W:0]       count;
    logic                  overrun;

    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic                  accept;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; a missed branch would infer a latch.
        push      = 1'b0;
        push_data = '0;
        if (TESTFIFO) begin
            push      = TestWrEn;
            push_data = PWDATAIn;
        end else if (MS) begin
            push      = SRxFWrEn;
            push_data = SRxFWrData;
        end else begin
            push      = MRxFWrEn;
            push_data = MRxFWrData;
        end
    end

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign pop    = RxFRdEn & ~RxFEmpty;
    assign accept = push & (~RxFFull | pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({accept, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the array is cleared on reset so no stale word can ever surface after a restart.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge PCLK) begin
        if (PRESET)                       overrun <= 1'b0;
        else if (push && RxFFull && !pop) overrun <= 1'b1;
        else if (OverrunClr)              overrun <= 1'b0;
    end

    assign RxFEmpty     = (count == '0);
    assign RxFFull      = (count == FULL_CNT);
    assign RxFCount     = count;
    assign RxFWatermark = (count >= WM_CNT);
    assign RxOverrun    = overrun;
    assign RxFRdData    = RxFEmpty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_ssp_rx_fifo.sv
// Bench for ssp_rx_fifo: a default instance (16b x 8, watermark 4) and a
// 8b x 16 instance (watermark 12) share stimulus and are checked against queue models.
module tb_ssp_rx_fifo;

    logic        pclk = 1'b0;
    logic        preset;
    logic        ms, testfifo;
    logic        mw_en, sw_en, tw_en, rd_en, ovr_clr;
    logic [15:0] mw_data, sw_data, tw_data;

    logic [15:0] a_rd_data;
    logic        a_empty, a_full, a_wm, a_ovr;
    logic [3:0]  a_count;
    logic [7:0]  b_rd_data;
    logic        b_empty, b_full, b_wm, b_ovr;
    logic [4:0]  b_count;

    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "init";

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    bit          ova, ovb;

    always #5 pclk = ~pclk;

    ssp_rx_fifo dut_a (
        .PCLK(pclk), .PRESET(preset), .MS(ms), .TESTFIFO(testfifo),
        .MRxFWrEn(mw_en), .MRxFWrData(mw_data),
        .SRxFWrEn(sw_en), .SRxFWrData(sw_data),
        .TestWrEn(tw_en), .PWDATAIn(tw_data),
        .RxFRdEn(rd_en), .OverrunClr(ovr_clr),
        .RxFRdData(a_rd_data), .RxFEmpty(a_empty), .RxFFull(a_full),
        .RxFCount(a_count), .RxFWatermark(a_wm), .RxOverrun(a_ovr)
    );

    ssp_rx_fifo #(.DATA_WIDTH(8), .ADDR_W(4), .WATERMARK(12)) dut_b (
        .PCLK(pclk), .PRESET(preset), .MS(ms), .TESTFIFO(testfifo),
        .MRxFWrEn(mw_en), .MRxFWrData(mw_data[7:0]),
        .SRxFWrEn(sw_en), .SRxFWrData(sw_data[7:0]),
        .TestWrEn(tw_en), .PWDATAIn(tw_data[7:0]),
        .RxFRdEn(rd_en), .OverrunClr(ovr_clr),
        .RxFRdData(b_rd_data), .RxFEmpty(b_empty), .RxFFull(b_full),
        .RxFCount(b_count), .RxFWatermark(b_wm), .RxOverrun(b_ovr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    task automatic check_models();
        check("a_data",  {16'h0, a_rd_data}, (qa.size() != 0) ? {16'h0, qa[0]} : 32'h0);
        check("a_empty", {31'h0, a_empty},   {31'h0, qa.size() == 0});
        check("a_full",  {31'h0, a_full},    {31'h0, qa.size() == 8});
        check("a_count", {28'h0, a_count},   qa.size());
        check("a_wm",    {31'h0, a_wm},      {31'h0, qa.size() >= 4});
        check("a_ovr",   {31'h0, a_ovr},     {31'h0, ova});
        check("b_data",  {24'h0, b_rd_data}, (qb.size() != 0) ? {16'h0, qb[0]} : 32'h0);
        check("b_empty", {31'h0, b_empty},   {31'h0, qb.size() == 0});
        check("b_full",  {31'h0, b_full},    {31'h0, qb.size() == 16});
        check("b_count", {27'h0, b_count},   qb.size());
        check("b_wm",    {31'h0, b_wm},      {31'h0, qb.size() >= 12});
        check("b_ovr",   {31'h0, b_ovr},     {31'h0, ovb});
    endtask

    // One clock: derive each model's next state from the FIFO rules, clock, compare.
    task automatic cycle();
        logic [15:0] q[$];
        logic [15:0] nqa[$];
        logic [15:0] nqb[$];
        bit          ov, nova, novb, push, pop, full;
        int          depth;
        logic [15:0] d;
        push = testfifo ? tw_en : (ms ? sw_en : mw_en);
        d    = testfifo ? tw_data : (ms ? sw_data : mw_data);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                q = qa; ov = ova; depth = 8;
            end else begin
                q = qb; ov = ovb; depth = 16; d = d & 16'h00FF;
            end
            if (preset) begin
                q.delete();
                ov = 1'b0;
            end else begin
                full = (q.size() == depth);
                pop  = rd_en && (q.size() != 0);
                if (push && full && !pop) ov = 1'b1;
                else if (ovr_clr)         ov = 1'b0;
                if (pop) q.delete(0);
                if (push && (!full || pop)) q.push_back(d);
            end
            if (k == 0) begin nqa = q; nova = ov; end
            else        begin nqb = q; novb = ov; end
        end
        @(posedge pclk);
        #1;
        qa = nqa; ova = nova;
        qb = nqb; ovb = novb;
        check_models();
    endtask

    task automatic idle();
        preset = 1'b0; mw_en = 1'b0; sw_en = 1'b0; tw_en = 1'b0;
        rd_en = 1'b0; ovr_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        preset = 1'b1;
        cycle();
        preset = 1'b0;
    endtask

    task automatic test_push(input logic [15:0] d);
        idle();
        testfifo = 1'b1; tw_en = 1'b1; tw_data = d;
        cycle();
        idle();
    endtask

    task automatic do_pop();
        idle();
        rd_en = 1'b1;
        cycle();
        idle();
    endtask

    initial begin
        preset = 1'b1; ms = 1'b0; testfifo = 1'b0;
        mw_en = 1'b0; sw_en = 1'b0; tw_en = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
        mw_data = '0; sw_data = '0; tw_data = '0;
        ova = 1'b0; ovb = 1'b0;
        #2;

        phase = "reset";
        do_reset();
        check("rst_data", {16'h0, a_rd_data}, 32'h0);
        check("rst_empty", {31'h0, a_empty}, 32'h1);

        phase = "fill_drain";
        for (int i = 1; i <= 8; i++) begin
            test_push(16'(i));
            check("wm_rise", {31'h0, a_wm}, (i >= 4) ? 32'h1 : 32'h0);
        end
        check("full8", {31'h0, a_full}, 32'h1);
        check("count8", {28'h0, a_count}, 32'h8);
        check("head1", {16'h0, a_rd_data}, 32'h1);
        for (int i = 1; i <= 8; i++) begin
            check("order", {16'h0, a_rd_data}, i);
            do_pop();
        end
        check("drained_empty", {31'h0, a_empty}, 32'h1);
        check("drained_data", {16'h0, a_rd_data}, 32'h0);

        phase = "source_sel";
        idle();
        testfifo = 1'b0; ms = 1'b0;
        mw_en = 1'b1; mw_data = 16'hA5A5; sw_en = 1'b1; sw_data = 16'h5A5A;
        cycle();
        mw_en = 1'b0;
        cycle();
        cycle();
        check("master_only", {28'h0, a_count}, 32'h1);
        check("master_word", {16'h0, a_rd_data}, 32'hA5A5);
        ms = 1'b1; sw_data = 16'h1234;
        cycle();
        idle();
        check("slave_count", {28'h0, a_count}, 32'h2);
        do_pop();
        check("slave_word", {16'h0, a_rd_data}, 32'h1234);
        do_pop();

        phase = "overrun";
        for (int i = 1; i <= 8; i++) test_push(16'(i));
        test_push(16'hDEAD);
        check("ovr_set", {31'h0, a_ovr}, 32'h1);
        check("ovr_count", {28'h0, a_count}, 32'h8);
        check("ovr_head", {16'h0, a_rd_data}, 32'h1);
        idle();
        tw_en = 1'b1; tw_data = 16'hBEEF; ovr_clr = 1'b1;
        cycle();
        check("set_beats_clr", {31'h0, a_ovr}, 32'h1);
        idle();
        ovr_clr = 1'b1;
        cycle();
        check("ovr_clear", {31'h0, a_ovr}, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            check("ovr_order", {16'h0, a_rd_data}, i);
            do_pop();
        end

        phase = "full_push_pop";
        for (int i = 1; i <= 8; i++) test_push(16'(i));
        idle();
        testfifo = 1'b1; tw_en = 1'b1; tw_data = 16'h0009; rd_en = 1'b1;
        cycle();
        idle();
        check("fpp_count", {28'h0, a_count}, 32'h8);
        check("fpp_no_ovr", {31'h0, a_ovr}, 32'h0);
        for (int i = 2; i <= 9; i++) begin
            check("fpp_order", {16'h0, a_rd_data}, i);
            do_pop();
        end
        tw_en = 1'b1; tw_data = 16'h0042; rd_en = 1'b1;
        cycle();
        idle();
        check("empty_push_pop", {28'h0, a_count}, 32'h1);
        do_pop();

        phase = "mid_reset";
        for (int i = 1; i <= 3; i++) test_push(16'(16'h30 + i));
        do_pop();
        do_pop();
        tw_en = 1'b1; tw_data = 16'h00EE; rd_en = 1'b1; preset = 1'b1;
        cycle();
        idle();
        check("mr_count", {28'h0, a_count}, 32'h0);
        check("mr_empty", {31'h0, a_empty}, 32'h1);
        check("mr_data", {16'h0, a_rd_data}, 32'h0);
        test_push(16'h0077);
        check("mr_push_data", {16'h0, a_rd_data}, 32'h0077);
        check("mr_push_count", {28'h0, a_count}, 32'h1);

        phase = "wide_depth";
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            test_push(16'(16'h10 + i - 1));
            check("b_wm_rise", {31'h0, b_wm}, (i >= 12) ? 32'h1 : 32'h0);
        end
        check("b_full16", {31'h0, b_full}, 32'h1);
        for (int j = 0; j < 16; j++) begin
            testfifo = 1'b1; tw_en = 1'b1; tw_data = 16'(16'h40 + j); rd_en = 1'b1;
            cycle();
            check("b_wrap_head", {24'h0, b_rd_data}, (j < 15) ? 32'(16'h11 + j) : 32'h40);
            check("b_wrap_count", {27'h0, b_count}, 32'd16);
        end
        idle();
        for (int j = 0; j < 16; j++) begin
            check("b_wrap_order", {24'h0, b_rd_data}, 32'(16'h40 + j));
            do_pop();
        end

        phase = "random";
        do_reset();
        for (int blk = 0; blk < 24; blk++) begin
            int rd_pct;
            rd_pct = (blk % 3 == 0) ? 15 : ((blk % 3 == 1) ? 50 : 85);
            for (int c = 0; c < 80; c++) begin
                ms       = 1'($urandom);
                testfifo = ($urandom_range(0, 3) == 0);
                mw_en    = ($urandom_range(0, 2) != 0);
                sw_en    = ($urandom_range(0, 2) != 0);
                tw_en    = ($urandom_range(0, 2) != 0);
                mw_data  = 16'($urandom);
                sw_data  = 16'($urandom);
                tw_data  = 16'($urandom);
                rd_en    = ($urandom_range(0, 99) < rd_pct);
                ovr_clr  = ($urandom_range(0, 7) == 0);
                preset   = ($urandom_range(0, 199) == 0);
                cycle();
            end
        end
        idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
